cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates the common data bus among the execute-stage functional units (ALUs, the pipelined multiplier, load unit). Every cycle it grants up to `NUM_CDB` requesting units a broadcast slot. The grant drives each unit's `cdb_en`, so the unit's last stage advances at the same clock edge. The granted results are registered and broadcast on the CDB the next cycle to the RS, ROB, map table and free list.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting functional units; bit/index `i` is FU `i`.
- `NUM_CDB`, default 2: broadcast slots per cycle; 1 ≤ `NUM_CDB` ≤ `NUM_FU`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `fu_req`  in  `NUM_FU`: FU `i` holds a completed result (the multiplier's `cdb_valid`).
- `fu_packets`  in  `CDB_REG_PACKET [NUM_FU]`: result, completing_reg and valid per FU.
- `fu_grant`  out  `NUM_FU`: combinational grant, wired to each FU's `cdb_en`.
- `cdb_out`  out  `CDB_REG_PACKET [NUM_CDB]`: registered broadcast slots.
- `cdb_busy`  out  1: registered; high when the previous cycle had more requests than slots.

## Operation
- **State:**
  - `rr_ptr` (`$clog2(NUM_FU)` bits): FU index with highest priority this cycle.
  - `cdb_out` registers.
  - `cdb_busy` register.
- **Selection:**
  - Scan FUs circularly from `rr_ptr`: `rr_ptr`, `rr_ptr+1`, …, wrapping mod `NUM_FU`.
  - The first `min(popcount(fu_req), NUM_CDB)` requesters are granted.
  - The k-th granted FU in scan order fills slot k (k = 0 first).
- **Unused slots:** slots with no grant latch `valid=0`; their result and completing_reg are don't-care.
- **Validity rule:** `fu_req[i]=1` with `fu_packets[i].valid=0` is an FU protocol violation. The arbiter still grants on `fu_req`. The slot copies the packet's `valid` bit unchanged.
- **Pointer update:**
  - ≥1 grant this cycle: `rr_ptr <= (index of last granted FU + 1) mod NUM_FU`.
  - No grants: `rr_ptr` holds.
- **Busy flag:** `cdb_busy <= (popcount(fu_req) > NUM_CDB)`.
- **Fairness:** an FU holding `fu_req` continuously is granted within `ceil(NUM_FU/NUM_CDB)` cycles.
- **Squash:** the arbiter applies no branch masks. FUs squash their own packets before requesting. A squashed FU drops `fu_req` in the same cycle; the arbiter responds combinationally.

## Timing
- **Reset values:** `rr_ptr=0`, every `cdb_out[k].valid=0`, `cdb_out` result and completing_reg = 0, `cdb_busy=0`.
- **Grant during reset:** `fu_grant` is forced to 0 in any cycle `reset` is high, even with requests present.
- **Grant path:** `fu_grant` is purely combinational from `fu_req` and `rr_ptr`. Grant in cycle N means:
  - the FU's last stage advances at edge N→N+1;
  - `cdb_out` shows the packet during cycle N+1.
- **Latency:** one cycle from grant to broadcast. An ungranted FU keeps requesting with an unchanged packet; the mult last stage holds because `cdb_en=0`.
- **Boundaries:**
  - Wrap-around: `rr_ptr=NUM_FU-1` scans `NUM_FU-1, 0, 1, …`.
  - Last granted FU is `NUM_FU-1`: `rr_ptr` wraps to 0.
  - All FUs requesting: exactly `NUM_CDB` grants.
  - No requests: all slots invalid next cycle, `rr_ptr` unchanged.
  - Reset asserted mid-stream: next cycle `cdb_out` is all invalid and `rr_ptr=0`. Packets in flight were discarded when reset cleared the FUs.
- **No back-to-back restriction:** the same FU may be granted every cycle if it is the only requester.

## Structure
- `CDB_REG_PACKET`, `` `NUM_FU `` and `` `NUM_CDB `` go in `sys_defs.svh`; no new typedefs.
- One sub-module, `cdb_rr_picker`. It is combinational; given `req`, `ptr` and the slot count it returns:
  - the grant vector;
  - the per-slot FU index plus slot valid;
  - the last-granted index.
- `cdb_arbiter` owns `rr_ptr`, the output registers and `cdb_busy`.

## Test plan
- **Reset with traffic:** reset with `fu_req=4'b1111` → `fu_grant=0` during reset; next cycle all `cdb_out[k].valid=0`, `rr_ptr=0`.
- **Single requester:**
  - Setup: `fu_req=4'b0100`, FU2 completing_reg=7, result=32'h2A.
  - Response: `fu_grant=4'b0100` same cycle; next cycle `cdb_out[0]` = {valid=1, reg 7, 32'h2A} and `cdb_out[1].valid=0`; `rr_ptr=3`.
- **Oversubscription and rotation:**
  - Stimulus: `fu_req=4'b1111` held, `NUM_CDB=2`.
  - Grants: 0011 → 1100 → 0011 → …
  - Registered outputs: `cdb_busy=1` each following cycle.
- **Wrap-around:**
  - Setup: `rr_ptr=3`, `fu_req=4'b1001`.
  - Response: grants FU3 (slot0) and FU0 (slot1); `rr_ptr=1`.
- **Mult backpressure:**
  - Stimulus: mult plus 2 ALUs requesting every cycle, `NUM_CDB=2`.
  - Response: the mult holds its last-stage packet while `cdb_en=0` and is broadcast within 2 cycles; no packet is duplicated or lost (check against a scoreboard).
- **Fairness:** random `fu_req` for 10k cycles → no continuously requesting FU waits more than `ceil(NUM_FU/NUM_CDB)` cycles; every granted packet appears exactly once, one cycle later.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and sizing for the common-data-bus arbiter.
//   - CDB_REG_PACKET: one broadcast slot (result, destination physical
//     register, valid).
//   - ptr_width(): width of a round-robin index over n units. It never
//     returns less than 1, so a single-FU build still gets a legal vector.
package cdb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int PHYS_REG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [PHYS_REG_W-1:0] completing_reg;
    logic                  valid;
  } CDB_REG_PACKET;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker
//   Purely combinational round-robin selector. It scans the request vector
//   circularly, starting at ptr, and grants the first NUM_CDB requesters.
//   The k-th grant in scan order is assigned to slot k.
//   Ports:
//     req        in  NUM_FU       request vector, bit i = FU i
//     ptr        in  PTR_W        highest-priority FU index this cycle
//     grant      out NUM_FU       one-hot-per-FU grant vector
//     slot_idx   out PTR_W x CDB  FU index feeding each slot
//     slot_valid out NUM_CDB      slot carries a granted FU
//     last_idx   out PTR_W        last FU granted in scan order
//                                 (meaningful only when grant != 0)
module cdb_rr_picker #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_FU-1:0]  req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_FU-1:0]  grant,
  output logic [PTR_W-1:0]   slot_idx [NUM_CDB],
  output logic [NUM_CDB-1:0] slot_valid,
  output logic [PTR_W-1:0]   last_idx
);

  always_comb begin
    int cnt;
    int pos;
    cnt        = 0;
    pos        = 0;
    grant      = '0;
    slot_valid = '0;
    last_idx   = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      slot_idx[k] = '0;
    end

    // Position j of the scan is FU (ptr + j) mod NUM_FU. The inner loop
    // over FUs turns the variable index into constant-index selects. At
    // most one FU matches each position.
    for (int j = 0; j < NUM_FU; j++) begin
      pos = int'(ptr) + j;
      if (pos >= NUM_FU) begin
        pos = pos - NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if ((i == pos) && req[i] && (cnt < NUM_CDB)) begin
          grant[i] = 1'b1;
          last_idx = PTR_W'(i);
          for (int k = 0; k < NUM_CDB; k++) begin
            if (k == cnt) begin
              slot_idx[k]   = PTR_W'(i);
              slot_valid[k] = 1'b1;
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares NUM_CDB broadcast slots among NUM_FU execute-stage units.
//   The grant is combinational and drives each FU's cdb_en, so a granted
//   unit's last stage advances on the same edge that latches its packet
//   into the broadcast registers. The packet appears on cdb_out one cycle
//   later.
//   Ports:
//     clock       in  1                 rising-edge clock
//     reset       in  1                 synchronous, active-high
//     fu_req      in  NUM_FU            FU i holds a completed result
//     fu_packets  in  CDB_REG_PACKET[]  per-FU result packets
//     fu_grant    out NUM_FU            combinational grant (cdb_en)
//     cdb_out     out CDB_REG_PACKET[]  registered broadcast slots
//     cdb_busy    out 1                 last cycle had more requests than slots
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_FU-1:0]   fu_req,
  input  CDB_REG_PACKET       fu_packets [NUM_FU],
  output logic [NUM_FU-1:0]   fu_grant,
  output CDB_REG_PACKET       cdb_out [NUM_CDB],
  output logic                cdb_busy
);

  localparam int PTR_W = ptr_width(NUM_FU);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [NUM_FU-1:0]  pick_grant;
  logic [PTR_W-1:0]   slot_idx [NUM_CDB];
  logic [NUM_CDB-1:0] slot_valid;
  logic [PTR_W-1:0]   last_idx;
  CDB_REG_PACKET      slot_pkt [NUM_CDB];

  cdb_rr_picker #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req        (fu_req),
    .ptr        (rr_ptr),
    .grant      (pick_grant),
    .slot_idx   (slot_idx),
    .slot_valid (slot_valid),
    .last_idx   (last_idx)
  );

  // While reset is high the FUs are being cleared. A grant would let a
  // last stage advance a packet that the output registers then discard.
  assign fu_grant = reset ? '0 : pick_grant;

  // Per-slot packet mux. The packet's own valid bit is carried through
  // unchanged, even if an FU requests with an invalid packet.
  for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_slot_mux
    assign slot_pkt[gi] = fu_packets[slot_idx[gi]];
  end

  // The pointer moves just past the last granted FU, so the units that
  // missed out this cycle lead the scan next cycle.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (|pick_grant) begin
      rr_ptr_next = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      cdb_busy <= 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_out[k] <= '0;
      end
    end else begin
      rr_ptr   <= rr_ptr_next;
      cdb_busy <= ($countones(fu_req) > NUM_CDB);
      for (int k = 0; k < NUM_CDB; k++) begin
        // Unused slots are cleared rather than holding stale data.
        cdb_out[k] <= slot_valid[k] ? slot_pkt[k] : '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter (NUM_FU=4, NUM_CDB=2). It runs a
//   hand-computed vector table, validity and reset corner cases, a mult
//   backpressure sequence and a long random run. The expected broadcast
//   for each cycle is queued when stimulus is driven. It is popped and
//   compared after the clock edge.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU  = 4;
  localparam int NUM_CDB = 2;
  localparam int CEIL    = (NUM_FU + NUM_CDB - 1) / NUM_CDB;

  logic                clock;
  logic                reset;
  logic [NUM_FU-1:0]   fu_req;
  CDB_REG_PACKET       pkts [NUM_FU];
  logic [NUM_FU-1:0]   fu_grant;
  CDB_REG_PACKET       cdb_out [NUM_CDB];
  logic                cdb_busy;

  cdb_arbiter #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_req     (fu_req),
    .fu_packets (pkts),
    .fu_grant   (fu_grant),
    .cdb_out    (cdb_out),
    .cdb_busy   (cdb_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    CDB_REG_PACKET [NUM_CDB-1:0] slots;
    logic [NUM_CDB-1:0]          used;
    logic                        busy;
    logic [1:0]                  ptr;
    logic                        rst_clear;
  } exp_t;

  typedef struct packed {
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [1:0]        ptr_after;
  } vec_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_ptr    = 0;
  int   wait_cnt [NUM_FU];
  int   next_id  = 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, req_v);
    end
  endfunction

  function automatic CDB_REG_PACKET fresh_pkt();
    CDB_REG_PACKET p;
    p.result         = 32'hA000_0000 + 32'(next_id);
    p.completing_reg = PHYS_REG_W'(next_id);
    p.valid          = 1'b1;
    next_id++;
    return p;
  endfunction

  // Called at posedge+1. It drives one cycle, checks the grant at the
  // negedge, then checks the registered outputs at the next posedge+1.
  task automatic cycle(input logic rst, input logic [NUM_FU-1:0] req,
                       output logic [NUM_FU-1:0] g_out);
    exp_t              e;
    logic [NUM_FU-1:0] mg;
    int                cnt;
    int                last;
    int                idx;
    reset  = rst;
    fu_req = req;
    mg     = '0;
    cnt    = 0;
    last   = -1;
    e      = '0;
    if (!rst) begin
      for (int j = 0; j < NUM_FU; j++) begin
        idx = (m_ptr + j) % NUM_FU;
        if (req[idx] && cnt < NUM_CDB) begin
          mg[idx]       = 1'b1;
          e.slots[cnt]  = pkts[idx];
          e.used[cnt]   = 1'b1;
          cnt++;
          last = idx;
        end
      end
    end
    e.busy = rst ? 1'b0 : ($countones(req) > NUM_CDB);
    if (rst) m_ptr = 0;
    else if (last >= 0) m_ptr = (last + 1) % NUM_FU;
    e.ptr       = 2'(m_ptr);
    e.rst_clear = rst;
    exp_q.push_back(e);

    #4;
    check("grant", 64'(fu_grant), 64'(mg));
    g_out = fu_grant;
    for (int i = 0; i < NUM_FU; i++) begin
      if (req[i] && !rst) begin
        if (fu_grant[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        check($sformatf("fair_wait_fu%0d", i), 64'(wait_cnt[i] < CEIL), 64'(1));
      end else begin
        wait_cnt[i] = 0;
      end
    end

    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    for (int k = 0; k < NUM_CDB; k++) begin
      if (e.used[k] || e.rst_clear)
        check($sformatf("cdb_slot%0d", k), 64'(cdb_out[k]), 64'(e.slots[k]));
      else
        check($sformatf("cdb_slot%0d_valid", k), 64'(cdb_out[k].valid), 64'(0));
    end
    check("cdb_busy", 64'(cdb_busy), 64'(e.busy));
    check("rr_ptr", 64'(dut.rr_ptr), 64'(e.ptr));
    $display("cyc %0d rst=%b req=%b grant=%b slot0=%b/%0d/%h slot1=%b/%0d/%h busy=%b",
             cyc, rst, req, g_out, cdb_out[0].valid, cdb_out[0].completing_reg,
             cdb_out[0].result, cdb_out[1].valid, cdb_out[1].completing_reg,
             cdb_out[1].result, cdb_busy);
    cyc++;
  endtask

  vec_t              vecs [10];
  logic [NUM_FU-1:0] g;
  logic [NUM_FU-1:0] req_r;

  initial begin
    reset  = 1'b1;
    fu_req = 4'b1111;
    for (int i = 0; i < NUM_FU; i++) begin
      pkts[i].result         = 32'h28 + 32'(i);
      pkts[i].completing_reg = PHYS_REG_W'(5 + i);
      pkts[i].valid          = 1'b1;
      wait_cnt[i]            = 0;
    end

    // Hand-computed sequence starting from rr_ptr=0 after reset.
    vecs[0] = '{req: 4'b1111, grant: 4'b0011, ptr_after: 2'd2};
    vecs[1] = '{req: 4'b1111, grant: 4'b1100, ptr_after: 2'd0};
    vecs[2] = '{req: 4'b1111, grant: 4'b0011, ptr_after: 2'd2};
    vecs[3] = '{req: 4'b0000, grant: 4'b0000, ptr_after: 2'd2};
    vecs[4] = '{req: 4'b0100, grant: 4'b0100, ptr_after: 2'd3};
    vecs[5] = '{req: 4'b1001, grant: 4'b1001, ptr_after: 2'd1};
    vecs[6] = '{req: 4'b0001, grant: 4'b0001, ptr_after: 2'd1};
    vecs[7] = '{req: 4'b1000, grant: 4'b1000, ptr_after: 2'd0};
    vecs[8] = '{req: 4'b1000, grant: 4'b1000, ptr_after: 2'd0};
    vecs[9] = '{req: 4'b0110, grant: 4'b0110, ptr_after: 2'd3};

    @(posedge clock);
    #1;

    // Reset with traffic present.
    cycle(1'b1, 4'b1111, g);
    cycle(1'b1, 4'b1111, g);

    for (int v = 0; v < 10; v++) begin
      cycle(1'b0, vecs[v].req, g);
      check($sformatf("tbl%0d_grant", v), 64'(g), 64'(vecs[v].grant));
      check($sformatf("tbl%0d_ptr", v), 64'(dut.rr_ptr), 64'(vecs[v].ptr_after));
    end

    // A request with an invalid packet is still granted. The slot copies
    // valid=0.
    pkts[1].valid = 1'b0;
    cycle(1'b0, 4'b0010, g);
    check("invalid_pkt_grant", 64'(g), 64'(4'b0010));
    check("invalid_pkt_slot_valid", 64'(cdb_out[0].valid), 64'(0));
    pkts[1].valid = 1'b1;

    // Reset in mid-stream.
    cycle(1'b0, 4'b1111, g);
    cycle(1'b1, 4'b1111, g);
    check("midreset_ptr", 64'(dut.rr_ptr), 64'(0));

    // Mult (FU3) and two ALUs requesting every cycle. Each unit gets a
    // new packet once granted, so a duplicate or a drop shows in the slots.
    for (int i = 0; i < NUM_FU; i++) pkts[i] = fresh_pkt();
    for (int n = 0; n < 8; n++) begin
      cycle(1'b0, 4'b1011, g);
      for (int i = 0; i < NUM_FU; i++) if (g[i]) pkts[i] = fresh_pkt();
    end

    // Random traffic. An ungranted requester holds its request and packet.
    req_r = '0;
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) begin
        cycle(1'b1, req_r, g);
        req_r = '0;
      end else begin
        cycle(1'b0, req_r, g);
        for (int i = 0; i < NUM_FU; i++) begin
          if (g[i] || !req_r[i]) begin
            req_r[i] = 1'($urandom_range(0, 1));
            pkts[i]  = fresh_pkt();
          end
        end
      end
    end

    reset  = 1'b0;
    fu_req = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
